// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
//   state_t    : converter FSM states
//   DIGIT_W    : bits per BCD digit
//   ADJ_THRESH : digit value at or above which the +3 correction applies
//   pow10(n)   : 10**n, used for the overflow threshold
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned ADJ_THRESH = 5;

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational shift-and-add-3 correction cell for one BCD digit.
//   digit    in  DIGIT_W  current scratch digit
//   adjusted out DIGIT_W  digit + 3 when digit >= ADJ_THRESH, else digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(ADJ_THRESH)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk_signal in  1           clock, posedge
//   reset      in  1           asynchronous active-high reset
//   start      in  1           conversion request, sampled only in IDLE
//   bin_in     in  BIN_WIDTH   binary value, captured on accepted start
//   busy       out 1           high from the cycle after accept until done
//   done       out 1           one-cycle pulse, bcd_out valid
//   bcd_out    out 4*DIGITS    packed BCD, [3:0] = ones
//   overflow   out 1           captured value was >= 10**DIGITS
// Option macro BCD_SATURATE_EN: overflowing results read as all nines instead
// of the low DIGITS decimal digits.
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                         clk_signal,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BIN_WIDTH-1:0]         bin_in,
  output logic                         busy,
  output logic                         done,
  output logic [DIGIT_W*DIGITS-1:0]    bcd_out,
  output logic                         overflow
);

  localparam int unsigned BCD_W     = DIGITS * DIGIT_W;
  // One spare digit so inputs up to 2**BIN_WIDTH-1 convert without wrapping.
  localparam int unsigned SCR_BCD_W = (DIGITS + 1) * DIGIT_W;
  localparam int unsigned SCR_W     = SCR_BCD_W + BIN_WIDTH;
  localparam int unsigned CNT_W     = $clog2(BIN_WIDTH);
  localparam logic [31:0] OVF_LIMIT = pow10(DIGITS);

  state_t             state_q, state_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               busy_d, done_d, overflow_d;
  logic [BCD_W-1:0]   bcd_d;

  logic [SCR_BCD_W-1:0] bcd_adj_c;
  logic [SCR_W-1:0]     scratch_shift_c;
  logic [BCD_W-1:0]     result_c;

  // Per-digit +3 correction on the BCD field of the scratch register.
  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch_q[BIN_WIDTH + g*DIGIT_W +: DIGIT_W]),
      .adjusted (bcd_adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign scratch_shift_c = {bcd_adj_c[SCR_BCD_W-2:0], scratch_q[BIN_WIDTH-1:0], 1'b0};

  // Final digits presented at done; the spare upper digit is dropped.
`ifdef BCD_SATURATE_EN
  assign result_c = ovf_q ? {DIGITS{4'h9}} : scratch_q[BIN_WIDTH +: BCD_W];
`else
  assign result_c = scratch_q[BIN_WIDTH +: BCD_W];
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy;
    done_d     = 1'b0;
    bcd_d      = bcd_out;
    overflow_d = overflow;
    case (state_q)
      IDLE: begin
        if (start) begin
          scratch_d = {SCR_BCD_W'(0), bin_in};
          cnt_d     = '0;
          ovf_d     = (32'(bin_in) >= OVF_LIMIT);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_shift_c;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d     = 1'b1;
        bcd_d      = result_c;
        overflow_d = ovf_q;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      busy      <= busy_d;
      done      <= done_d;
      bcd_out   <= bcd_d;
      overflow  <= overflow_d;
    end
  end

endmodule
